// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the pooling stage.
//   - MAT_MUL_SIZE / DWIDTH global macros (defaulted here if not provided)
//   - window encodings, FSM state enum, accumulator width, log2(W) lookup
// Optional feature macro: POOL_AVG_EN (average-pooling datapath).
`ifndef MAT_MUL_SIZE
`define MAT_MUL_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif

package pool_pkg;

  localparam int unsigned MMS = `MAT_MUL_SIZE;
  localparam int unsigned DW  = `DWIDTH;
  localparam int unsigned CW  = (MMS > 1) ? $clog2(MMS) : 1;

`ifdef POOL_AVG_EN
  // Headroom for summing up to 16 elements (4x4 window).
  localparam int unsigned ACC_WIDTH = DW + 4;
`else
  localparam int unsigned ACC_WIDTH = DW;
`endif

  typedef enum logic [1:0] {
    WIN_DEF = 2'b00,
    WIN_1   = 2'b01,
    WIN_2   = 2'b10,
    WIN_4   = 2'b11
  } win_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_e;

  // 00 is treated as a 1x1 window.
  function automatic logic [1:0] win_log2(input logic [1:0] enc);
    case (enc)
      WIN_2:   return 2'd1;
      WIN_4:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_group_reduce.sv
// pool_group_reduce: one output group of the pooling stage.
//   Horizontal reduce of the first W lanes of lanes_i, then vertical
//   accumulation over W rows (load on window row 0, combine afterwards).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   lanes_i      4 candidate lanes, lane k at [k*DW +: DW]
//   wlog_i       log2(W)
//   mode_i       0 = max, 1 = average (only with POOL_AVG_EN)
//   load_i       first row of the window: overwrite accumulator
//   acc_en_i     a row is accepted this cycle
//   result_o     reduced value including the current row
// Optional feature macro: POOL_AVG_EN.
module pool_group_reduce
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4*DW-1:0]   lanes_i,
  input  logic [1:0]        wlog_i,
  input  logic              mode_i,
  input  logic              load_i,
  input  logic              acc_en_i,
  output logic [DW-1:0]     result_o
);

  logic signed [DW-1:0]        ln [4];
  logic signed [ACC_WIDTH-1:0] h_max, comb, acc_d, acc_q;
  logic [2:0]                  wsize;
`ifdef POOL_AVG_EN
  logic signed [ACC_WIDTH-1:0] h_sum, shifted;
`else
  logic                        unused_mode;
`endif

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) ln[k] = lanes_i[k*DW +: DW];
  end

  always_comb begin
    wsize = 3'd1 << wlog_i;
    h_max = ACC_WIDTH'(ln[0]);
    for (int unsigned k = 1; k < 4; k++) begin
      if (k < 32'(wsize) && ACC_WIDTH'(ln[k]) > h_max) h_max = ACC_WIDTH'(ln[k]);
    end
`ifdef POOL_AVG_EN
    h_sum = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < 32'(wsize)) h_sum = h_sum + ACC_WIDTH'(ln[k]);
    end
    if (mode_i) comb = load_i ? h_sum : acc_q + h_sum;
    else        comb = load_i ? h_max : ((h_max > acc_q) ? h_max : acc_q);
    // Arithmetic shift by 2*log2(W) divides by W*W, flooring toward -inf.
    shifted  = comb >>> {wlog_i, 1'b0};
    result_o = mode_i ? shifted[DW-1:0] : comb[DW-1:0];
`else
    unused_mode = mode_i;
    comb        = load_i ? h_max : ((h_max > acc_q) ? h_max : acc_q);
    result_o    = comb[DW-1:0];
`endif
    acc_d = acc_en_i ? comb : acc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/pool.sv
// pool: spatial max/average pooling over WxW tiles (W = 1, 2, 4) of
//   MAT_MUL_SIZE x MAT_MUL_SIZE frames, one input row per cycle.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   enable_pool          0 = combinational bypass
//   pool_window_size     01=W1, 10=W2, 11=W4, 00=W1 (latched per frame)
//   pool_mode            0=max, 1=average (latched per frame)
//   in_data_available    inp_data valid
//   inp_data             input row, lane i at [i*DWIDTH +: DWIDTH]
//   out_data             pooled row (registered, 0 outside pulses)
//   out_data_available   one-cycle pulse per completed window row
//   done_pool            frame complete (sticky until input goes idle)
// Optional feature macro: POOL_AVG_EN (enables average mode).
module pool
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_pool,
  input  logic [1:0]        pool_window_size,
  input  logic              pool_mode,
  input  logic              in_data_available,
  input  logic [MMS*DW-1:0] inp_data,
  output logic [MMS*DW-1:0] out_data,
  output logic              out_data_available,
  output logic              done_pool
);

  state_e            state_q, state_d;
  logic [1:0]        wlog_q, wlog_d, wlog;
  logic              mode_q, mode_d, mode;
  logic [CW-1:0]     row_cnt_q, row_cnt_d;
  logic [1:0]        win_cnt_q, win_cnt_d;
  logic [MMS*DW-1:0] out_q, out_d;
  logic              avail_q, avail_d;
  logic [2:0]        wsize;
  logic              rst_int, accept, emit, win_last, last_row;
  logic [4*DW-1:0]   grp_lanes [MMS];
  logic [DW-1:0]     grp_res   [MMS];

  // Bypass holds all internal state in reset.
  always_comb rst_int = reset | ~enable_pool;

  // Window and mode come straight from the inputs on the frame's first row,
  // from the latched copies for the rest of the frame.
  always_comb begin
    wlog     = (state_q == S_IDLE) ? win_log2(pool_window_size) : wlog_q;
    mode     = (state_q == S_IDLE) ? pool_mode : mode_q;
    wsize    = 3'd1 << wlog;
    accept   = in_data_available && (state_q != S_DONE);
    win_last = (win_cnt_q == 2'(wsize - 3'd1));
    emit     = accept && win_last;
    last_row = (row_cnt_q == CW'(MMS - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_int) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_data_available) state_d = last_row ? S_DONE : S_ACC;
      S_ACC: begin
        if (!in_data_available) state_d = S_IDLE;
        else if (last_row)      state_d = S_DONE;
      end
      S_DONE:  if (!in_data_available) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    if (enable_pool) begin
      out_data           = out_q;
      out_data_available = avail_q;
      done_pool          = (state_q == S_DONE);
    end else begin
      out_data           = inp_data;
      out_data_available = in_data_available;
      done_pool          = 1'b1;
    end
  end

  // Counters clear whenever no row is accepted (idle, abort, or DONE).
  always_comb begin
    wlog_d    = wlog;
    mode_d    = mode;
    row_cnt_d = '0;
    win_cnt_d = '0;
    if (accept) begin
      row_cnt_d = last_row ? '0 : row_cnt_q + CW'(1);
      win_cnt_d = win_last ? '0 : win_cnt_q + 2'd1;
    end
  end

  // Group g covers lanes g*W .. g*W+W-1.
  always_comb begin
    for (int unsigned g = 0; g < MMS; g++) begin
      grp_lanes[g] = '0;
      for (int unsigned k = 0; k < 4; k++) begin
        if ((g << wlog) + k < MMS)
          grp_lanes[g][k*DW +: DW] = inp_data[((g << wlog) + k)*DW +: DW];
      end
    end
  end

  for (genvar g = 0; g < MMS; g++) begin : g_grp
    pool_group_reduce u_reduce (
      .clk      (clk),
      .reset    (rst_int),
      .lanes_i  (grp_lanes[g]),
      .wlog_i   (wlog),
      .mode_i   (mode),
      .load_i   (win_cnt_q == 2'd0),
      .acc_en_i (accept),
      .result_o (grp_res[g])
    );
  end

  // Only the first MMS/W groups are live; the rest pack as zero.
  always_comb begin
    out_d   = '0;
    avail_d = emit;
    if (emit) begin
      for (int unsigned g = 0; g < MMS; g++) begin
        if (g < (MMS >> wlog)) out_d[g*DW +: DW] = grp_res[g];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      wlog_q    <= '0;
      mode_q    <= 1'b0;
      row_cnt_q <= '0;
      win_cnt_q <= '0;
      out_q     <= '0;
      avail_q   <= 1'b0;
    end else begin
      wlog_q    <= wlog_d;
      mode_q    <= mode_d;
      row_cnt_q <= row_cnt_d;
      win_cnt_q <= win_cnt_d;
      out_q     <= out_d;
      avail_q   <= avail_d;
    end
  end

endmodule

// File: tb/tb_pool.sv
// tb_pool: self-checking bench for pool (MAT_MUL_SIZE=4, DWIDTH=8).
// Expected pulses are queued when the completing row is driven and popped
// by a monitor sampling 1 time unit after each rising edge.
module tb_pool;

  logic        clk = 1'b0;
  logic        reset, enable_pool, pool_mode, in_data_available;
  logic [1:0]  pool_window_size;
  logic [31:0] inp_data, out_data;
  logic        out_data_available, done_pool;

  always #5 clk = ~clk;

  pool dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pool        (enable_pool),
    .pool_window_size   (pool_window_size),
    .pool_mode          (pool_mode),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool)
  );

  typedef struct {
    logic [1:0]  win;
    logic        mode;
    logic [31:0] rows [4];
    logic [31:0] exp  [4];
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        done;
  } exp_t;

  int   checks = 0;
  int   passed = 0;
  bit   mon_on = 0;
  exp_t sb [$];
  vec_t vecs [$];

  // Lane 0 is the low byte: [1,-5,3,2] -> 0x0203FB01
  localparam logic [31:0] R0 = 32'h0203FB01;
  localparam logic [31:0] R1 = 32'h07FF0004;  // [4,0,-1,7]
  localparam logic [31:0] R2 = 32'h09090909;  // [9,9,9,9]
  localparam logic [31:0] R3 = 32'hF8FCFDFE;  // [-2,-3,-4,-8]
  localparam logic [31:0] AM3 = 32'hFDFDFDFD; // all -3

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic vec_t mk(input logic [1:0] win, input logic mode,
                              input logic [31:0] r0, r1, r2, r3,
                              input logic [31:0] e0, e1, e2, e3);
    vec_t v;
    v.win = win; v.mode = mode;
    v.rows[0] = r0; v.rows[1] = r1; v.rows[2] = r2; v.rows[3] = r3;
    v.exp[0]  = e0; v.exp[1]  = e1; v.exp[2]  = e2; v.exp[3]  = e3;
    return v;
  endfunction

  task automatic drive_row(input logic [31:0] d, input logic [1:0] w, input logic m);
    @(negedge clk);
    in_data_available = 1'b1;
    inp_data          = d;
    pool_window_size  = w;
    pool_mode         = m;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_data_available = 1'b0;
    inp_data          = $urandom;
  endtask

  // Full frame, window/mode inputs flipped after row 0 (they must be latched),
  // then `extra` rows while in DONE (must be ignored), then idle.
  task automatic run_frame(input vec_t v, input int unsigned extra);
    int unsigned w;
    exp_t e;
    w = (v.win == 2'b10) ? 2 : (v.win == 2'b11) ? 4 : 1;
    for (int unsigned i = 0; i < 4; i++) begin
      drive_row(v.rows[i], (i == 0) ? v.win : ~v.win, (i == 0) ? v.mode : ~v.mode);
      if ((i + 1) % w == 0) begin
        e.data = v.exp[(i + 1) / w - 1];
        e.done = (i == 3);
        sb.push_back(e);
      end
    end
    for (int unsigned x = 0; x < extra; x++) begin
      @(negedge clk);
      chk("done_sticky", {31'd0, done_pool}, 32'd1);
      in_data_available = 1'b1;
      inp_data          = $urandom;
    end
    @(negedge clk);
    chk("done_hold", {31'd0, done_pool}, 32'd1);
    in_data_available = 1'b0;
    @(negedge clk);
    chk("done_clear", {31'd0, done_pool}, 32'd0);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (out_data_available) begin
          if (sb.size() == 0) chk("unexpected_pulse", out_data, 32'hxxxxxxxx);
          else begin
            e = sb.pop_front();
            chk("pulse_data", out_data, e.data);
            chk("pulse_done", {31'd0, done_pool}, {31'd0, e.done});
          end
        end else begin
          chk("idle_zero", out_data, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk(2'b01, 1'b0, R0, R1, R2, R3, R0, R1, R2, R3));
    vecs.push_back(mk(2'b00, 1'b1, R3, R2, R1, R0, R3, R2, R1, R0));
    vecs.push_back(mk(2'b10, 1'b0, R0, R1, R2, R3, 32'h00000704, 32'h00000909, 0, 0));
    vecs.push_back(mk(2'b11, 1'b0, R0, R1, R2, R3, 32'h00000009, 0, 0, 0));
`ifdef POOL_AVG_EN
    vecs.push_back(mk(2'b11, 1'b1, 32'hFDFDFD0D, AM3, AM3, AM3, 32'h000000FE, 0, 0, 0));
    vecs.push_back(mk(2'b11, 1'b1, 32'hFDFDFD0C, AM3, AM3, AM3, 32'h000000FD, 0, 0, 0));
    vecs.push_back(mk(2'b10, 1'b1, R0, R1, R2, R3, 32'h00000200, 32'h00000103, 0, 0));
`else
    vecs.push_back(mk(2'b11, 1'b1, 32'hFDFDFD0D, AM3, AM3, AM3, 32'h0000000D, 0, 0, 0));
    vecs.push_back(mk(2'b10, 1'b1, R0, R1, R2, R3, 32'h00000704, 32'h00000909, 0, 0));
`endif

    reset = 1'b1; enable_pool = 1'b1; in_data_available = 1'b0;
    inp_data = '0; pool_window_size = 2'b00; pool_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_avail", {31'd0, out_data_available}, 32'd0);
    chk("rst_done", {31'd0, done_pool}, 32'd0);

    // Bypass: combinational pass-through
    reset = 1'b0; enable_pool = 1'b0;
    in_data_available = 1'b1; inp_data = 32'h01020304;
    #1;
    chk("byp_data0", out_data, 32'h01020304);
    chk("byp_avail0", {31'd0, out_data_available}, 32'd1);
    chk("byp_done0", {31'd0, done_pool}, 32'd1);
    @(negedge clk);
    inp_data = 32'h05060708;
    #1;
    chk("byp_data1", out_data, 32'h05060708);
    in_data_available = 1'b0;
    #1;
    chk("byp_avail_low", {31'd0, out_data_available}, 32'd0);
    chk("byp_done1", {31'd0, done_pool}, 32'd1);

    @(negedge clk);
    enable_pool = 1'b1;
    mon_on = 1;

    foreach (vecs[i]) run_frame(vecs[i], (i == 0) ? 2 : 0);

    // Abort: a lone W2 row followed by a gap must not leak into the next frame
    drive_row(R2, 2'b10, 1'b0);
    idle_cycle();
    run_frame(mk(2'b10, 1'b0, R0, R1, R2, R3, 32'h00000704, 32'h00000909, 0, 0), 0);

    // Reset on row 3 of a W4 frame, concurrent with a valid row
    drive_row(R2, 2'b11, 1'b0);
    drive_row(R2, 2'b11, 1'b0);
    @(negedge clk);
    reset = 1'b1; in_data_available = 1'b1; inp_data = R2;
    @(negedge clk);
    reset = 1'b0; in_data_available = 1'b0;
    chk("midrst_done", {31'd0, done_pool}, 32'd0);
    run_frame(mk(2'b11, 1'b0, R0, R1, R3, R1, 32'h00000007, 0, 0, 0), 0);

    @(negedge clk);
    mon_on = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pool.md
# pool

Spatial pooling stage directly downstream of normalization in the matmul output path. Consumes one normalized `MAT_MUL_SIZE`-element row per cycle. Reduces each W×W tile (W = 1, 2 or 4) by max, or optionally by average. Emits one packed row per W input rows toward the activation stage.

## Interface
- `MAT_MUL_SIZE`, 4: elements per row and rows per frame (global macro).
- `DWIDTH`, 8: element width, signed two's complement (global macro).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `enable_pool`  in  1  0 selects bypass.
- `pool_window_size`  in  2  01 = W1, 10 = W2, 11 = W4; 00 is treated as W1.
- `pool_mode`  in  1  0 = max, 1 = average (effective only with `POOL_AVG_EN`).
- `in_data_available`  in  1  `inp_data` valid this cycle.
- `inp_data`  in  `MAT_MUL_SIZE*DWIDTH`  input row; lane i at `[i*DWIDTH +: DWIDTH]`.
- `out_data`  out  `MAT_MUL_SIZE*DWIDTH`  pooled row.
- `out_data_available`  out  1  `out_data` valid.
- `done_pool`  out  1  frame complete.

## Operation
- **Bypass (`enable_pool`=0):** `out_data`=`inp_data`, `out_data_available`=`in_data_available`, `done_pool`=1, all combinational. Internal state is held in reset.
- **Window sampling:** W and mode are latched on the first accepted row of a frame (IDLE→ACC). They are ignored until the frame ends.
- **Horizontal reduction:** each row is cut into `MAT_MUL_SIZE/W` groups of W adjacent lanes. Each group is reduced to one value.
- **Vertical reduction:**
  - Per-group accumulators combine W consecutive rows.
  - The accumulator is loaded on window row 0 and combined on rows 1..W-1.
- **Max mode:** signed compare.
- **Average mode:**
  - Sum in `DWIDTH+4` bits.
  - Arithmetic right shift by 2·log2(W), which floors toward −∞.
  - The low `DWIDTH` bits form the result.
- **Output packing:**
  - Group g goes to lane g.
  - Lanes ≥ `MAT_MUL_SIZE/W` are zero.
- **FSM:**
  - IDLE: row_cnt=0, win_cnt=0. A valid row moves to ACC.
  - ACC: one row per valid cycle.
    - win_cnt wraps at W-1 and triggers an emit.
    - row_cnt reaching `MAT_MUL_SIZE`-1 goes to DONE.
  - DONE: `done_pool`=1, which is sticky.
    - Further valid rows are ignored and produce no output.
    - `in_data_available`=0 returns the FSM to IDLE.
- **Abort:** `in_data_available`=0 in ACC returns to IDLE and discards the partial window. Rows must be contiguous.
- **Reset:** reset at any cycle returns to IDLE and clears accumulators and counters. It overrides a simultaneous valid row.

## Timing
- Reset values: `out_data`=0, `out_data_available`=0, `done_pool`=0 (when enabled).
- Latency is 1 cycle: the output is registered on the edge that accepts the W-th row of a window. `out_data_available` is high for exactly that following cycle.
- W1: output every cycle, the input delayed by 1.
- W2: a pulse every 2nd row.
- W4: a single pulse after row 4.
- `done_pool` rises in the same cycle as the last `out_data_available` pulse of the frame.
- Outside pulses, `out_data` holds 0.
- No backpressure: the consumer must accept every pulse.

## Configuration
- `POOL_AVG_EN` defined: the sum/shift datapath is compiled in, and `pool_mode` selects max or average.
- `POOL_AVG_EN` undefined: max only. `pool_mode` is ignored and the accumulator is `DWIDTH` wide.

## Structure
- `pool_pkg` holds:
  - window encodings
  - FSM state enum (IDLE/ACC/DONE)
  - `ACC_WIDTH` = `DWIDTH+4` (or `DWIDTH` without `POOL_AVG_EN`)
  - the log2(W) lookup function
- Sub-module `pool_group_reduce`: one group, covering the W-lane horizontal reduce plus the vertical accumulator. It is instantiated `MAT_MUL_SIZE` times, and unused instances are masked by W.

## Test plan
- Bypass: `enable_pool`=0, rows 0x01020304 then 0x05060708 → output equals input the same cycle, `done_pool`=1.
- W1 max: 4 rows → each echoed 1 cycle later; `done_pool` with the 4th pulse.
- W2 max:
  - Rows [1,-5,3,2], [4,0,-1,7], [9,9,9,9], [-2,-3,-4,-8].
  - Expected pulses: [4,7,0,0] after row 2 and [9,9,0,0] after row 4.
- W4 average (`POOL_AVG_EN`): all 16 elements = -3 except one = 13 → sum -32, output [-2,0,0,0]; sum -33 → -3 (floor).
- Abort: W2, one row, then `in_data_available`=0 for 1 cycle, then 4 rows → only 2 pulses, no stale data mixed in.
- Reset mid-frame: reset asserted on a valid row 3 of W4 → no pulse. The next frame's first output uses only the new rows.
